// File: rtl/ring_arb_pkg.sv
// Shared types and defaults for the ring-token round-robin arbiter.
// The optional hold-timeout feature is selected with the RING_ARB_TIMEOUT_EN macro.
package ring_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEFAULT_WIDTH    = 4;
    localparam int DEFAULT_MAX_HOLD = 15;

endpackage : ring_arb_pkg

// File: rtl/ring_token.sv
// One-hot ring register holding the round-robin priority pointer.
// Resets to bit 0; on adv it loads the rotate-left of load_val.
module ring_token
    import ring_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] token
);

    logic [WIDTH-1:0] token_q;
    logic [WIDTH-1:0] token_d;

    assign token_d = {load_val[WIDTH-2:0], load_val[WIDTH-1]};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            token_q <= WIDTH'(1);
        end else if (adv) begin
            token_q <= token_d;
        end
    end

    assign token = token_q;

endmodule : ring_token

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring token; grant held until done.
// Define RING_ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             done,
    output logic [WIDTH-1:0] grant,
    output logic             busy,
    output logic [WIDTH-1:0] token,
    output logic             timeout
);

    if (WIDTH < 2) begin : g_bad_width
        $error("ring_rr_arbiter: WIDTH must be >= 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("ring_rr_arbiter: MAX_HOLD must be >= 1");
    end

    arb_state_e         state_q;
    logic [WIDTH-1:0]   grant_q;
    logic               busy_q;
    logic [WIDTH-1:0]   token_w;
    logic [WIDTH-1:0]   pick;
    logic [2*WIDTH-1:0] req_dbl;
    logic [2*WIDTH-1:0] sel_dbl;
    logic               force_rel;
    logic               release_w;

    // Doubling req lets the borrow of (req - token) find the first set bit at
    // or above the token, wrapping into the upper copy when needed.
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        req_dbl = {req, req};
        sel_dbl = req_dbl & ~(req_dbl - {{WIDTH{1'b0}}, token_w});
        pick    = sel_dbl[WIDTH-1:0] | sel_dbl[2*WIDTH-1:WIDTH];
    end

    assign release_w = (state_q == GRANT) && (done || force_rel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q <= pick;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_w) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    ring_token #(
        .WIDTH(WIDTH)
    ) u_ring_token (
        .clk      (clk),
        .rst      (rst),
        .adv      (release_w),
        .load_val (grant_q),
        .token    (token_w)
    );

`ifdef RING_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              timeout_q;

    // A done arriving on the limit cycle wins: that is an ordinary release.
    assign force_rel = (state_q == GRANT) && !done && (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            if (state_q == IDLE) begin
                hold_q <= '0;
            end else if (!done) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign grant = grant_q;
    assign busy  = busy_q;
    assign token = token_w;

endmodule : ring_rr_arbiter
